hazard_unit: RTL and testbench

Parametrised forwarding and hazard controller for the in-order integer pipeline. Generates per-operand forward selects for the instruction in EX, and detects load-use and multi-cycle-unit (MUL/DIV) hazards for the instruction in ID. Tracks one outstanding multi-cycle operation with an internal latency counter and produces its writeback pulse. Sits beside the ID/EX pipeline registers and drives the stall and bubble controls and the EX operand muxes.

---
 rtl/hazard_unit.sv | 128 ++++++++++++
 tb/tb_hazard_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Forwarding selects, load-use / multi-cycle-unit stall detection, and a tracker
// for one outstanding multi-cycle op that produces its writeback strobe.
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_is_mc,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mc_start,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic                      wb_reg_write,
  input  logic                      mc_kill,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      id_stall,
  output logic                      ex_bubble,
  output logic                      mc_busy,
  output logic                      mc_wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] mc_wb_addr,
  output logic                      mc_overrun
);

  localparam int CW = $clog2(MC_LATENCY) + 1;
  // BUSY lasts MC_LATENCY-1 cycles, so the counter starts at MC_LATENCY-2.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } mc_state_t;

  mc_state_t                 state_reg;
  logic [CW-1:0]             cnt_reg;
  logic [REG_ADDR_WIDTH-1:0] mc_wb_addr_reg;
  logic                      overrun_reg;

  logic [REG_ADDR_WIDTH-1:0] ex_rs   [2];
  logic [1:0]                fwd_sel [2];
  logic                      load_use;
  logic                      sb_hazard;
  logic                      hazard;

  function automatic logic hit(input logic [REG_ADDR_WIDTH-1:0] a,
                               input logic [REG_ADDR_WIDTH-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  assign mc_busy     = (state_reg != IDLE);
  assign mc_wb_valid = (state_reg == WB) && !mc_kill;
  assign mc_wb_addr  = mc_wb_addr_reg;
  assign mc_overrun  = overrun_reg;

  assign ex_rs[0] = ex_rs1_addr;
  assign ex_rs[1] = ex_rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] = rst                                          ? 2'd0 :
                           (mem_reg_write && hit(ex_rs[gi], mem_rd_addr)) ? 2'd1 :
                           (wb_reg_write  && hit(ex_rs[gi], wb_rd_addr))  ? 2'd2 :
                           (mc_wb_valid   && hit(ex_rs[gi], mc_wb_addr_reg)) ? 2'd3 :
                                                                            2'd0;
    end
  endgenerate

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  assign load_use = id_valid && ex_reg_write && (ex_mem_read || ex_mc_start) &&
                    (hit(id_rs1_addr, ex_rd_addr) || hit(id_rs2_addr, ex_rd_addr));

  // In the WB cycle the regfile is written, so dependents proceed without stalling.
  assign sb_hazard = id_valid && mc_busy && !mc_wb_valid &&
                     (hit(id_rs1_addr, mc_wb_addr_reg) || hit(id_rs2_addr, mc_wb_addr_reg) ||
                      hit(id_rd_addr, mc_wb_addr_reg) || id_is_mc);

  assign hazard    = !rst && (load_use || sb_hazard);
  assign id_stall  = hazard;
  assign ex_bubble = hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      mc_wb_addr_reg <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      if (ex_mc_start && mc_busy && !mc_kill)
        overrun_reg <= 1'b1;
      if (mc_kill) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (ex_mc_start) begin
              mc_wb_addr_reg <= ex_rd_addr;
              cnt_reg        <= CNT_LOAD;
              state_reg      <= BUSY;
            end
          end
          BUSY: begin
            if (cnt_reg == '0)
              state_reg <= WB;
            else
              cnt_reg <= cnt_reg - 1'b1;
          end
          WB:      state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: per-cycle expectations and MC writeback
// addresses are queued by the driver and checked by independent monitors.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_is_mc;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic       ex_reg_write, ex_mem_read, ex_mc_start;
  logic [4:0] mem_rd_addr, wb_rd_addr;
  logic       mem_reg_write, wb_reg_write, mc_kill;
  logic [1:0] fwd_a, fwd_b;
  logic       id_stall, ex_bubble, mc_busy, mc_wb_valid, mc_overrun;
  logic [4:0] mc_wb_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    bit         cm;
    logic [13:0] vec;
  } exp_t;

  exp_t       expq[$];
  logic [4:0] wbq[$];

  hazard_unit #(.REG_ADDR_WIDTH(5), .MC_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_is_mc(id_is_mc),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .mc_kill(mc_kill),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .id_stall(id_stall), .ex_bubble(ex_bubble),
    .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid), .mc_wb_addr(mc_wb_addr),
    .mc_overrun(mc_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: act=running req=finished");
    $fatal(1, "timeout");
  end

  // Per-cycle monitor plus MC writeback scoreboard, both sampled on the falling edge.
  always @(negedge clk) begin
    logic [13:0] act, mask;
    exp_t        e;
    logic [4:0]  a;
    if (expq.size() > 0) begin
      e    = expq.pop_front();
      act  = {fwd_a, fwd_b, id_stall, ex_bubble, mc_busy, mc_wb_valid, mc_overrun, mc_wb_addr};
      mask = {6'h3f, (e.cm ? 8'hff : 8'h00)};
      checks++;
      if (((act ^ e.vec) & mask) !== 14'd0) begin
        errors++;
        $display("FAIL %s: act fa=%0d fb=%0d st=%b bub=%b busy=%b wbv=%b ovr=%b wba=%0d req fa=%0d fb=%0d st=%b busy=%b wbv=%b ovr=%b wba=%0d (mc %s)",
                 e.name, fwd_a, fwd_b, id_stall, ex_bubble, mc_busy, mc_wb_valid, mc_overrun, mc_wb_addr,
                 e.vec[13:12], e.vec[11:10], e.vec[9], e.vec[7], e.vec[6], e.vec[5], e.vec[4:0],
                 e.cm ? "checked" : "ignored");
      end else begin
        $display("ok   %s: fa=%0d fb=%0d st=%b busy=%b wbv=%b ovr=%b wba=%0d",
                 e.name, fwd_a, fwd_b, id_stall, mc_busy, mc_wb_valid, mc_overrun, mc_wb_addr);
      end
    end
    if (mc_wb_valid === 1'b1) begin
      checks++;
      if (wbq.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: act wb strobe addr=%0d req no strobe", mc_wb_addr);
      end else begin
        a = wbq.pop_front();
        if (mc_wb_addr !== a) begin
          errors++;
          $display("FAIL wb_addr: act=%0d req=%0d", mc_wb_addr, a);
        end
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_is_mc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    ex_rs1_addr = 0; ex_rs2_addr = 0; ex_rd_addr = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mc_start = 0;
    mem_rd_addr = 0; mem_reg_write = 0; wb_rd_addr = 0; wb_reg_write = 0; mc_kill = 0;
  endtask

  // Queue the expectation for the current cycle's inputs, then advance one cycle.
  task automatic chk(input string nm, input bit cm, input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic busy, input logic wbv, input logic ovr,
                     input logic [4:0] wba);
    exp_t e;
    e.name = nm;
    e.cm   = cm;
    e.vec  = {fa, fb, st, st, busy, wbv, ovr, wba};
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic mc_start(input logic [4:0] rd);
    ex_mc_start = 1; ex_reg_write = 1; ex_rd_addr = rd;
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    // Reset: conflicting inputs must not leak through.
    ex_rs1_addr = 5; mem_rd_addr = 5; mem_reg_write = 1;
    id_valid = 1; id_rs1_addr = 7; ex_rd_addr = 7; ex_reg_write = 1; ex_mem_read = 1;
    chk("reset_gate", 1, 0, 0, 0, 0, 0, 0, 0);
    clr();
    rst = 0;

    // MEM/WB forwarding priority.
    ex_rs1_addr = 5; ex_rs2_addr = 3; mem_rd_addr = 5; mem_reg_write = 1; wb_rd_addr = 5; wb_reg_write = 1;
    chk("fwd_mem_prio", 1, 1, 0, 0, 0, 0, 0, 0);
    mem_reg_write = 0;
    chk("fwd_wb", 1, 2, 0, 0, 0, 0, 0, 0);
    ex_rs1_addr = 0; ex_rs2_addr = 0; mem_rd_addr = 0; mem_reg_write = 1; wb_rd_addr = 0; wb_reg_write = 1;
    chk("fwd_r0", 1, 0, 0, 0, 0, 0, 0, 0);
    ex_rs1_addr = 7; ex_rs2_addr = 6; mem_rd_addr = 6; mem_reg_write = 0; wb_rd_addr = 6; wb_reg_write = 1;
    chk("fwd_b_wb", 1, 0, 2, 0, 0, 0, 0, 0);
    clr();

    // Load-use: one stall cycle, then clear once the load is in MEM.
    id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 7; ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 7;
    chk("loaduse_stall", 1, 0, 0, 1, 0, 0, 0, 0);
    ex_mem_read = 0; ex_reg_write = 0; ex_rd_addr = 0; mem_rd_addr = 7; mem_reg_write = 1;
    chk("loaduse_release", 1, 0, 0, 0, 0, 0, 0, 0);
    clr();
    id_valid = 1; id_rs1_addr = 0; ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 0;
    chk("loaduse_r0", 1, 0, 0, 0, 0, 0, 0, 0);
    clr();

    // MC latency with a dependent reader of x9.
    id_valid = 1; id_rs1_addr = 9; mc_start(9); wbq.push_back(5'd9);
    chk("mc_t0", 1, 0, 0, 1, 0, 0, 0, 0);
    clr(); id_valid = 1; id_rs1_addr = 9;
    chk("mc_t1", 1, 0, 0, 1, 1, 0, 0, 9);
    chk("mc_t2", 1, 0, 0, 1, 1, 0, 0, 9);
    chk("mc_t3", 1, 0, 0, 1, 1, 0, 0, 9);
    ex_rs1_addr = 9;
    chk("mc_t4_wb", 1, 3, 0, 0, 1, 1, 0, 9);
    clr(); ex_rs1_addr = 9;
    chk("mc_t5_idle", 1, 0, 0, 0, 0, 0, 0, 9);
    clr();

    // Structural hazard, WAW and overrun.
    mc_start(12); wbq.push_back(5'd12);
    chk("ovr_t0", 1, 0, 0, 0, 0, 0, 0, 9);
    clr(); id_valid = 1; id_is_mc = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 3;
    chk("struct_t1", 1, 0, 0, 1, 1, 0, 0, 12);
    clr(); mc_start(13);
    chk("ovr_start_t2", 1, 0, 0, 0, 1, 0, 0, 12);
    clr(); id_valid = 1; id_rd_addr = 12;
    chk("waw_t3", 1, 0, 0, 1, 1, 0, 1, 12);
    chk("waw_wb_t4", 1, 0, 0, 0, 1, 1, 1, 12);
    clr();
    chk("ovr_sticky_t5", 1, 0, 0, 0, 0, 0, 1, 12);

    // Reset mid-op discards the pending op.
    mc_start(20);
    chk("rstop_t0", 1, 0, 0, 0, 0, 0, 1, 12);
    clr();
    chk("rstop_t1", 1, 0, 0, 0, 1, 0, 1, 20);
    rst = 1; ex_rs1_addr = 5; mem_rd_addr = 5; mem_reg_write = 1;
    id_valid = 1; id_rs1_addr = 20;
    chk("rstop_t2_gate", 0, 0, 0, 0, 0, 0, 0, 0);
    clr(); rst = 0;
    chk("rstop_t3", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("rstop_t4", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("rstop_t5", 1, 0, 0, 0, 0, 0, 0, 0);

    // Kill during the WB cycle suppresses the strobe.
    mc_start(15);
    chk("kill_t0", 1, 0, 0, 0, 0, 0, 0, 0);
    clr();
    chk("kill_t1", 1, 0, 0, 0, 1, 0, 0, 15);
    chk("kill_t2", 1, 0, 0, 0, 1, 0, 0, 15);
    chk("kill_t3", 1, 0, 0, 0, 1, 0, 0, 15);
    mc_kill = 1; ex_rs1_addr = 15;
    chk("kill_t4_wb", 1, 0, 0, 0, 1, 0, 0, 15);
    clr();
    chk("kill_t5", 1, 0, 0, 0, 0, 0, 0, 15);

    // Kill plus start in the same cycle, from IDLE and from BUSY.
    mc_start(17); mc_kill = 1;
    chk("killstart_idle", 1, 0, 0, 0, 0, 0, 0, 15);
    clr();
    chk("killstart_idle_n", 1, 0, 0, 0, 0, 0, 0, 15);
    mc_start(18);
    chk("ks_busy_t0", 1, 0, 0, 0, 0, 0, 0, 15);
    clr();
    chk("ks_busy_t1", 1, 0, 0, 0, 1, 0, 0, 18);
    mc_start(19); mc_kill = 1;
    chk("ks_busy_t2", 1, 0, 0, 0, 1, 0, 0, 18);
    clr();
    chk("ks_busy_t3", 1, 0, 0, 0, 0, 0, 0, 18);
    chk("ks_busy_t4", 1, 0, 0, 0, 0, 0, 0, 18);
    chk("ks_busy_t5", 1, 0, 0, 0, 0, 0, 0, 18);

    @(negedge clk);
    #1;
    checks++;
    if (wbq.size() != 0 || expq.size() != 0) begin
      errors++;
      $display("FAIL drain: act pending_wb=%0d pending_exp=%0d req 0 and 0", wbq.size(), expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
